// File: rtl/ram_ctrl.sv
// Parametrised single-port register-file RAM with a valid/busy/done command front end,
// a multi-cycle CLEAR/FILL sweep and illegal-opcode reporting. Optional macro: RAM_CTRL_PARITY_EN.
module ram_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        op,
    input  logic              op_valid,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef RAM_CTRL_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_READ   = 3'd2,
        S_WRITE  = 3'd3,
        S_SWEEP  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [2:0]          r_op;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_din;
    logic [ADDR_W-1:0]   r_cnt;
    logic [DATA_W-1:0]   r_dout;
    logic                r_done;
    logic                r_err;
    logic [MEM_W-1:0]    r_mem [DEPTH];

    logic                w_accept;
    logic                w_we;
    logic [ADDR_W-1:0]   w_waddr;
    logic [MEM_W-1:0]    w_wdata;
    logic [MEM_W-1:0]    w_rd_word;
    logic                w_par_err;
    logic                w_err_set;
    logic                w_sweep_last;

    // The stored word carries an even-parity bit above the data when parity is built in.
    function automatic logic [MEM_W-1:0] f_encode(input logic [DATA_W-1:0] d);
`ifdef RAM_CTRL_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    // A stored word with correct even parity XORs to zero across all its bits.
    function automatic logic f_parity_bad(input logic [MEM_W-1:0] w);
`ifdef RAM_CTRL_PARITY_EN
        return ^w;
`else
        return (w != w);
`endif
    endfunction

    assign w_accept     = (r_state == S_IDLE) && op_valid && (op != 3'd0);
    assign w_rd_word    = r_mem[r_addr];
    assign w_par_err    = f_parity_bad(w_rd_word);
    assign w_sweep_last = (r_cnt == {ADDR_W{1'b1}});

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign err      = r_err;
    assign data_out = r_dout;

    // Next-state decode plus RAM write-port steering.
    always_comb begin
        w_next    = r_state;
        w_we      = 1'b0;
        w_waddr   = r_addr;
        w_wdata   = f_encode(r_din);
        w_err_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_DECODE;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_DECODE: begin
                case (r_op)
                    3'd1:    w_next = S_READ;
                    3'd2:    w_next = S_WRITE;
                    3'd3:    w_next = S_SWEEP;
                    3'd4:    w_next = S_SWEEP;
                    default: begin
                        w_next    = S_DONE;
                        w_err_set = 1'b1;
                    end
                endcase
            end
            S_READ: begin
                w_next    = S_DONE;
                w_err_set = w_par_err;
            end
            S_WRITE: begin
                w_we   = 1'b1;
                w_next = S_DONE;
            end
            S_SWEEP: begin
                w_we    = 1'b1;
                w_waddr = r_cnt;
                if (r_op == 3'd3) begin
                    w_wdata = f_encode({DATA_W{1'b0}});
                end else begin
                    w_wdata = f_encode(r_din);
                end
                if (w_sweep_last) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_SWEEP;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Control state, command capture, sweep counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= 3'd0;
            r_addr  <= {ADDR_W{1'b0}};
            r_din   <= {DATA_W{1'b0}};
            r_cnt   <= {ADDR_W{1'b0}};
            r_dout  <= {DATA_W{1'b0}};
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (w_next == S_DONE);
            r_err   <= w_err_set;
            if (w_accept) begin
                r_op   <= op;
                r_addr <= addr;
                r_din  <= data_in;
            end
            if (r_state == S_SWEEP) begin
                r_cnt <= w_sweep_last ? {ADDR_W{1'b0}} : r_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
            if (r_state == S_READ) begin
                r_dout <= w_rd_word[DATA_W-1:0];
            end
        end
    end

    // Storage is deliberately not reset so an aborted sweep leaves untouched words intact.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

endmodule

// File: tb/tb_ram_ctrl.sv
// Scoreboard bench for ram_ctrl: stimulus pushes expected completions, a monitor checks each done.
module tb_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  op = 3'd0;
    logic        op_valid = 1'b0;
    logic [3:0]  addr = 4'd0;
    logic [15:0] data_in = 16'd0;
    logic [15:0] data_out;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          lat;
        int          acc;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    ram_ctrl #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .op_valid(op_valid), .addr(addr),
        .data_in(data_in), .data_out(data_out), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.nm, "_data"}, int'(data_out), int'(e.data));
                chk({e.nm, "_err"},  int'(err),      int'(e.err));
                chk({e.nm, "_lat"},  cyc - e.acc,    e.lat);
            end
        end
    end

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        if (!ok) chk("idle_timeout", 1, 0);
    endtask

    task automatic issue(input string nm, input logic [2:0] o, input logic [3:0] a,
                         input logic [15:0] d, input bit expect_done,
                         input logic [15:0] e_data, input logic e_err, input int e_lat);
        exp_t e;
        wait_idle();
        op = o; addr = a; data_in = d; op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        if (expect_done) begin
            e.data = e_data; e.err = e_err; e.lat = e_lat; e.acc = cyc; e.nm = nm;
            q.push_back(e);
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_dout"}, int'(data_out), 0);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_done"}, int'(done), 0);
        chk({nm, "_err"},  int'(err), 0);
    endtask

    initial begin
        exp_t e;
        bit   drained;
        #12;
        chk_reset_outputs("por");
        @(negedge clk); rst_n = 1'b1;

        issue("rd5_after_reset", 3'd1, 4'd5, 16'h0000, 1'b1, 16'h0000, 1'b0, 2);

        // WRITE, then a READ held while busy that must only be taken once IDLE
        issue("wr3", 3'd2, 4'd3, 16'hBEEF, 1'b1, 16'h0000, 1'b0, 2);
        op = 3'd1; addr = 4'd3; data_in = 16'h0000; op_valid = 1'b1;
        wait_idle();
        @(posedge clk); #1;
        op_valid = 1'b0;
        e.data = 16'hBEEF; e.err = 1'b0; e.lat = 2; e.acc = cyc; e.nm = "rd3_held";
        q.push_back(e);

        issue("fill", 3'd4, 4'd0, 16'hA5A5, 1'b1, 16'hBEEF, 1'b0, 17);
        repeat (3) @(negedge clk);
        op = 3'd2; addr = 4'd0; data_in = 16'h1234; op_valid = 1'b1;
        @(negedge clk); op_valid = 1'b0;

        issue("rd0_fill",  3'd1, 4'd0,  16'h0000, 1'b1, 16'hA5A5, 1'b0, 2);
        issue("rd15_fill", 3'd1, 4'd15, 16'h0000, 1'b1, 16'hA5A5, 1'b0, 2);
        issue("rd3_fill",  3'd1, 4'd3,  16'h0000, 1'b1, 16'hA5A5, 1'b0, 2);

        // CLEAR aborted by reset after words 0..7 have been written
        issue("clear", 3'd3, 4'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 0);
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("mid_clear_rst");
        @(negedge clk); rst_n = 1'b1;

        issue("rd2_clr",  3'd1, 4'd2,  16'h0000, 1'b1, 16'h0000, 1'b0, 2);
        issue("rd12_clr", 3'd1, 4'd12, 16'h0000, 1'b1, 16'hA5A5, 1'b0, 2);
        issue("rd7_clr",  3'd1, 4'd7,  16'h0000, 1'b1, 16'h0000, 1'b0, 2);
        issue("rd8_clr",  3'd1, 4'd8,  16'h0000, 1'b1, 16'hA5A5, 1'b0, 2);

        issue("ill6",     3'd6, 4'd8,  16'h0000, 1'b1, 16'hA5A5, 1'b1, 1);
        issue("rd8_ill",  3'd1, 4'd8,  16'h0000, 1'b1, 16'hA5A5, 1'b0, 2);
        issue("ill5",     3'd5, 4'd2,  16'hFFFF, 1'b1, 16'hA5A5, 1'b1, 1);
        issue("rd2_ill",  3'd1, 4'd2,  16'h0000, 1'b1, 16'h0000, 1'b0, 2);

        issue("wr15",     3'd2, 4'd15, 16'h0001, 1'b1, 16'h0000, 1'b0, 2);
        issue("rd15",     3'd1, 4'd15, 16'h0000, 1'b1, 16'h0001, 1'b0, 2);

`ifdef RAM_CTRL_PARITY_EN
        issue("wr7_par",  3'd2, 4'd7,  16'h0001, 1'b1, 16'h0001, 1'b0, 2);
        wait_idle();
        dut.r_mem[7][0] = ~dut.r_mem[7][0];
        issue("rd7_par",  3'd1, 4'd7,  16'h0000, 1'b1, 16'h0000, 1'b1, 2);
`endif

        drained = 1'b0;
        for (int i = 0; i < 100 && !drained; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !busy) drained = 1'b1;
        end
        repeat (2) @(negedge clk);
        chk("pending_expected", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
